// File: rtl/mux_stream_nx1.sv
// N-to-1 valid/ready stream multiplexer with fixed-select and round-robin
// arbitration feeding a one-entry registered output stage.
module mux_stream_nx1 #(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int SW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   Sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_next;
  logic [SW-1:0] rr_g;
  logic [N-1:0]  rr_hi;
  logic          fx_exists;
  logic [SW-1:0] grant;
  logic          grant_exists;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  sel_data;

  // Fixed select: an out-of-range Sel matches no channel, so it never grants.
  always_comb begin
    fx_exists = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (Sel == SW'(i)) fx_exists = in_valid[i];
    end
  end

  // Round-robin: lowest valid channel at or above rr_ptr wins, else lowest valid overall.
  always_comb begin
    rr_hi = '0;
    rr_g  = '0;
    for (int i = 0; i < N; i++) begin
      rr_hi[i] = in_valid[i] && (SW'(i) >= rr_ptr);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) rr_g = SW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rr_hi[i]) rr_g = SW'(i);
    end
  end

  always_comb begin
    grant        = mode ? rr_g : Sel;
    grant_exists = mode ? (|in_valid) : fx_exists;
    load_en      = !out_valid || out_ready;
    xfer         = load_en && grant_exists && rst_n;
    rr_next      = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
  end

  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        sel_data    = in_data[i*W +: W];
        in_ready[i] = xfer;
      end
    end
  end

  // Output holding register; a new beat may load in the same cycle the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant;
        if (mode) rr_ptr <= rr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// Self-checking bench for mux_stream_nx1: reference model compared every cycle
// plus directed scenarios with literal expectations.
module tb_mux_stream_nx1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mode = 1'b0;
  logic [3:0]    Sel = '0;
  logic [127:0]  in_data = '0;
  logic [15:0]   in_valid = '0;
  logic [15:0]   in_ready;
  logic [7:0]    out_data;
  logic [3:0]    out_ch;
  logic          out_valid;
  logic          out_ready = 1'b0;

  logic          mode12 = 1'b0;
  logic [3:0]    sel12 = '0;
  logic [95:0]   in_data12 = '0;
  logic [11:0]   in_valid12 = '0;
  logic [11:0]   in_ready12;
  logic [7:0]    out_data12;
  logic [3:0]    out_ch12;
  logic          out_valid12;
  logic          out_ready12 = 1'b0;

  int nvec  = 0;
  int nfail = 0;

  logic          m_valid = 1'b0;
  logic [7:0]    m_data = '0;
  int            m_ch = 0;
  int            m_ptr = 0;
  logic          m_ex;
  int            m_g;
  logic [15:0]   m_rdy;

  mux_stream_nx1 #(.N(16), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .Sel(Sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_stream_nx1 #(.N(12), .W(8)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .mode(mode12), .Sel(sel12),
    .in_data(in_data12), .in_valid(in_valid12), .in_ready(in_ready12),
    .out_data(out_data12), .out_ch(out_ch12), .out_valid(out_valid12),
    .out_ready(out_ready12)
  );

  always #5 clk = ~clk;

  // Reference grant: fixed index, or first valid channel scanning up from the pointer.
  always_comb begin
    m_ex = 1'b0;
    m_g  = 0;
    if (!mode) begin
      if (in_valid[Sel]) begin
        m_ex = 1'b1;
        m_g  = int'(Sel);
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (!m_ex && in_valid[(m_ptr + k) % 16]) begin
          m_ex = 1'b1;
          m_g  = (m_ptr + k) % 16;
        end
      end
    end
    m_rdy = (rst_n && (!m_valid || out_ready) && m_ex) ? 16'(1 << m_g) : 16'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_ptr   <= 0;
    end else if ((!m_valid || out_ready) && m_ex) begin
      m_valid <= 1'b1;
      m_data  <= in_data[m_g*8 +: 8];
      m_ch    <= m_g;
      if (mode) m_ptr <= (m_g + 1) % 16;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_out_valid", 64'(out_valid), 64'(m_valid));
    checkOutput("model_out_data", 64'(out_data), 64'(m_data));
    checkOutput("model_out_ch", 64'(out_ch), 64'(m_ch));
    checkOutput("model_in_ready", 64'(in_ready), 64'(m_rdy));
  end

  task automatic applyStimulus(input logic md, input logic [3:0] s, input logic [15:0] v, input logic ordy);
    mode      = md;
    Sel       = s;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_seq [8] = '{0, 5, 10, 15, 0, 5, 10, 15};
    int sw_seq [4]  = '{2, 2, 2, 7};

    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = {~4'(i), 4'(i)};
    for (int i = 0; i < 12; i++) in_data12[i*8 +: 8] = {~4'(i), 4'(i)};

    #1 rst_n = 1'b0;
    repeat (2) tick();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_ch", 64'(out_ch), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fixed select of channel 5
    applyStimulus(1'b0, 4'd5, 16'hFFFF, 1'b1);
    checkOutput("fixed_in_ready", 64'(in_ready), 64'h0020);
    tick();
    checkOutput("fixed_out_data", 64'(out_data), 64'hA5);
    checkOutput("fixed_out_ch", 64'(out_ch), 64'd5);
    checkOutput("fixed_out_valid", 64'(out_valid), 64'd1);

    // Round-robin over a sparse valid set
    applyStimulus(1'b1, 4'd0, 16'h8421, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("rr_out_ch_%0d", c), 64'(out_ch), 64'(exp_seq[c]));
    end

    // Backpressure holds the registered beat
    applyStimulus(1'b0, 4'd12, 16'hFFFF, 1'b1);
    tick();
    checkOutput("bp_load_data", 64'(out_data), 64'h3C);
    applyStimulus(1'b0, 4'd12, 16'hFFFF, 1'b0);
    checkOutput("bp_in_ready_0", 64'(in_ready), 64'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("bp_hold_data", 64'(out_data), 64'h3C);
      checkOutput("bp_hold_ch", 64'(out_ch), 64'd12);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'h0);
    end
    applyStimulus(1'b0, 4'd3, 16'hFFFF, 1'b1);
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'h0008);
    tick();
    checkOutput("bp_release_data", 64'(out_data), 64'hC3);
    checkOutput("bp_release_ch", 64'(out_ch), 64'd3);
    checkOutput("bp_release_valid", 64'(out_valid), 64'd1);

    // Mode switch: park pointer at 7, run fixed select, return to round-robin
    applyStimulus(1'b1, 4'd0, 16'h0040, 1'b1);
    tick();
    checkOutput("sw_park_ch", 64'(out_ch), 64'd6);
    applyStimulus(1'b0, 4'd2, 16'hFFFF, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) applyStimulus(1'b1, 4'd2, 16'hFFFF, 1'b1);
      tick();
      checkOutput($sformatf("sw_out_ch_%0d", c), 64'(out_ch), 64'(sw_seq[c]));
    end

    // Channels drop valid while the beat is stalled
    applyStimulus(1'b1, 4'd0, 16'h0000, 1'b0);
    repeat (2) tick();
    checkOutput("drop_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("drop_hold_data", 64'(out_data), 64'h87);
    applyStimulus(1'b1, 4'd0, 16'h0000, 1'b1);
    tick();
    checkOutput("drop_drain_valid", 64'(out_valid), 64'd0);
    checkOutput("drop_drain_ch", 64'(out_ch), 64'd7);

    // Asynchronous reset while a beat is held
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1);
    tick();
    checkOutput("pre_reset_ch", 64'(out_ch), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_out_ch", 64'(out_ch), 64'd0);
    checkOutput("async_out_data", 64'(out_data), 64'd0);
    checkOutput("async_in_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("post_reset_ch0", 64'(out_ch), 64'd0);
    tick();
    checkOutput("post_reset_ch1", 64'(out_ch), 64'd1);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    tick();

    // Out-of-range select on a 12-channel instance
    mode12      = 1'b0;
    sel12       = 4'd13;
    in_valid12  = 12'hFFF;
    out_ready12 = 1'b1;
    #1;
    checkOutput("oor_in_ready", 64'(in_ready12), 64'h0);
    repeat (2) tick();
    checkOutput("oor_out_valid", 64'(out_valid12), 64'd0);
    sel12 = 4'd11;
    #1;
    checkOutput("n12_in_ready", 64'(in_ready12), 64'h800);
    tick();
    checkOutput("n12_out_ch", 64'(out_ch12), 64'd11);
    checkOutput("n12_out_data", 64'(out_data12), 64'h4B);
    checkOutput("n12_out_valid", 64'(out_valid12), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mux_stream_nx1.md
MUX_STREAM_NX1 -- requirements
Module: mux_stream_nx1

Interface
REQ-001 SHALL have parameter N, default 16, number of input channels (legal 2..32).
REQ-002 SHALL have parameter W, default 8, data width per channel (legal 1..64).
REQ-003 SHALL derive local SW = max(1, ceil(log2(N))) as the channel-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port Sel  input  SW  channel index used in fixed mode.
REQ-008 SHALL have port in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-009 SHALL have port in_valid  input  N  per-channel valid.
REQ-010 SHALL have port in_ready  output  N  per-channel ready, combinational.
REQ-011 SHALL have port out_data  output  W  registered selected data.
REQ-012 SHALL have port out_ch  output  SW  registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  registered output valid.
REQ-014 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-015 SHALL transfer on any interface only in a cycle where valid and ready are both 1 at the rising edge.
REQ-016 SHALL compute load_en = !out_valid | out_ready. The one-entry output register accepts new data when empty or draining in the same cycle.
REQ-017 SHALL, in mode 0, grant channel Sel when Sel < N and in_valid[Sel] = 1; otherwise no grant.
REQ-018 SHALL, in mode 1, grant the first channel with in_valid = 1 found by searching upward from rr_ptr with wrap N-1 -> 0.
REQ-019 SHALL update rr_ptr to (g+1) mod N only on a mode-1 transfer from channel g. rr_ptr is unchanged in mode 0 and in stall cycles.
REQ-020 SHALL drive in_ready[i] = load_en & grant_exists & (grant == i), so at most one in_ready bit is 1 per cycle.
REQ-021 SHALL, on an input transfer, register out_data = channel data, out_ch = grant, and out_valid = 1 at the same edge (latency 1 cycle).
REQ-022 SHALL clear out_valid at the edge where out_valid & out_ready holds and no new input transfer occurs.
REQ-023 SHALL hold out_data, out_ch and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL sustain one transfer per cycle when out_ready is held at 1 and a grant exists every cycle.
REQ-025 SHALL ignore in_data of non-granted channels and Sel while mode = 1.
REQ-026 SHALL apply a change of mode or Sel to the grant in the same cycle; an already-registered output is unaffected.
REQ-027 SHALL treat Sel >= N (non-power-of-2 N) as no grant, with all in_ready = 0.
REQ-028 SHALL hold a registered beat while channels drop in_valid; no beat is lost or duplicated.

Reset
REQ-029 SHALL, while rst_n = 0, force out_valid = 0, out_data = 0, out_ch = 0 and rr_ptr = 0 immediately, without waiting for clk.
REQ-030 SHALL drive in_ready = 0 whenever rst_n = 0.
REQ-031 SHALL discard any beat registered at the moment reset is asserted mid-operation.
REQ-032 SHALL resume normal operation at the first rising edge after rst_n returns to 1.

Verification
REQ-033 Fixed select: N=16, W=8, mode=0, Sel=5, in_valid=16'hFFFF, ch5 data 8'hA5, out_ready=1. Required: in_ready=16'h0020; next cycle out_data=8'hA5, out_ch=5, out_valid=1.
REQ-034 Round-robin fairness: mode=1, in_valid=16'h8421, out_ready=1 for 8 cycles. Required: out_ch sequence 0,5,10,15,0,5,10,15.
REQ-035 Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 4 cycles with in_valid all 1s. Required: outputs unchanged and in_ready=0 throughout; on the first cycle out_ready=1, the next beat loads with no gap.
REQ-036 Out-of-range select: N=12, mode=0, Sel=13, in_valid all 1s. Required: in_ready=0 and out_valid stays 0.
REQ-037 Async reset mid-stream: rst_n pulled low between clock edges while out_valid=1. Required: out_valid=0, out_ch=0, out_data=0 before the next edge; after release the round-robin search starts from channel 0.
REQ-038 Mode switch: mode 1 with rr_ptr=7, switch to mode 0 with Sel=2 for 3 transfers, then back to mode 1 with all channels valid. Required: out_ch sequence 2,2,2,7.
